axi_read_fifo_responder: RTL and testbench

Read-path counterpart of the AXI write-side FIFO interface. Pops read addresses from the AXI read-address FIFO and decodes each one to the controller memory, the register file or an unmapped hole. Issues a single read strobe, waits the target's fixed latency, and pushes read data plus a response code into the AXI read-data FIFO. Sits between the AXI slave front end and the memory/register decoder.

---
 rtl/axi_read_fifo_responder.sv | 120 ++++++++++++
 tb/tb_axi_read_fifo_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_fifo_responder.sv
// rtl/axi_read_fifo_responder.sv - pops AXI read addresses, reads mem/regs/DECERR, pushes read data
// One request in flight; each request is decoded once in ISSUE and its result is held in data_q/resp_q until pushed.
module axi_read_fifo_responder #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned SEL_BIT     = 17,
  parameter int unsigned REG_BIT     = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] addr_fifo_i,
  input  logic        addr_empty,
  output logic        addr_read_en,
  output logic        mem_rd,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        reg_rd,
  output logic [31:0] reg_addr_o,
  input  logic [31:0] reg_data_i,
  input  logic        data_fifo_full,
  output logic        data_fifo_wr_en,
  output logic [31:0] data_fifo_o,
  output logic [1:0]  resp_o,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] PUSH  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  resp_q, resp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rst_dly_q;
  logic        pop, push;
  logic        sel_mapped, sel_reg;

  assign sel_mapped = addr_q[SEL_BIT];
  assign sel_reg    = addr_q[REG_BIT];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // No pop in the cycle right after reset, so every output is quiet then.
        if (!addr_empty && !rst_dly_q) begin
          pop     = 1'b1;
          addr_d  = addr_fifo_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!sel_mapped) begin
          data_d  = 32'h0;
          resp_d  = RESP_DECERR;
          state_d = PUSH;
        end else begin
          cnt_d   = sel_reg ? 4'd0 : 4'(MEM_LATENCY - 1);
          resp_d  = RESP_OKAY;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          data_d  = sel_reg ? reg_data_i : mem_data_i;
          state_d = PUSH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PUSH: begin
        if (!data_fifo_full) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    rst_dly_q <= Rst;
    if (Rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      resp_q  <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is forced low while reset is asserted, even mid-request.
  assign addr_read_en    = !Rst && pop;
  assign mem_rd          = !Rst && (state_q == ISSUE) && sel_mapped && !sel_reg;
  assign reg_rd          = !Rst && (state_q == ISSUE) && sel_mapped && sel_reg;
  assign mem_addr_o      = mem_rd ? addr_q : 32'h0;
  assign reg_addr_o      = reg_rd ? addr_q : 32'h0;
  assign data_fifo_wr_en = !Rst && push;
  assign data_fifo_o     = Rst ? 32'h0 : data_q;
  assign resp_o          = Rst ? 2'b00 : resp_q;
  assign busy            = !Rst && (state_q != IDLE);

endmodule

// File: tb/tb_axi_read_fifo_responder.sv
// tb/tb_axi_read_fifo_responder.sv - directed vector bench for axi_read_fifo_responder
module tb_axi_read_fifo_responder;

  localparam int MEM_LAT = 2;

  logic        Clk;
  logic        Rst;
  logic [31:0] addr_fifo_i;
  logic        addr_empty;
  logic        addr_read_en;
  logic        mem_rd;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        reg_rd;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_data_i;
  logic        data_fifo_full;
  logic        data_fifo_wr_en;
  logic [31:0] data_fifo_o;
  logic [1:0]  resp_o;
  logic        busy;

  axi_read_fifo_responder #(
    .MEM_LATENCY(MEM_LAT),
    .SEL_BIT    (17),
    .REG_BIT    (8)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .addr_fifo_i    (addr_fifo_i),
    .addr_empty     (addr_empty),
    .addr_read_en   (addr_read_en),
    .mem_rd         (mem_rd),
    .mem_addr_o     (mem_addr_o),
    .mem_data_i     (mem_data_i),
    .reg_rd         (reg_rd),
    .reg_addr_o     (reg_addr_o),
    .reg_data_i     (reg_data_i),
    .data_fifo_full (data_fifo_full),
    .data_fifo_wr_en(data_fifo_wr_en),
    .data_fifo_o    (data_fifo_o),
    .resp_o         (resp_o),
    .busy           (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  wire any_out = addr_read_en | mem_rd | reg_rd | data_fifo_wr_en | busy |
                 (|resp_o) | (|mem_addr_o) | (|reg_addr_o) | (|data_fifo_o);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] reg_val;
    logic [31:0] mem_val;
    int          exp_mem_n;
    int          exp_reg_n;
    int          exp_push_k;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Entered one tick after an edge with the DUT idle; k counts cycles from the strobe cycle T.
  task automatic run_vec(input vec_t v, input string tag);
    int          push_k = -1;
    int          push_n = 0;
    int          mem_n  = 0;
    int          reg_n  = 0;
    int          pop_n  = 0;
    logic [31:0] saddr  = 32'h0;
    logic [31:0] pdata  = 32'h0;
    logic [1:0]  presp  = 2'b00;
    data_fifo_full = 1'b0;
    addr_fifo_i    = v.addr;
    addr_empty     = 1'b0;
    #1;
    check({tag, " pop"}, addr_read_en, 1);
    step();
    addr_empty = 1'b1;
    for (int k = 0; k < 8; k++) begin
      reg_data_i = (k == 1) ? v.reg_val : 32'h5555_AAAA;
      mem_data_i = (k == MEM_LAT) ? v.mem_val : ((k == 1) ? 32'h0000_0BAD : 32'h6666_9999);
      #1;
      if (k == 0) check({tag, " busy"}, busy, 1);
      if (mem_rd) begin mem_n++; saddr = mem_addr_o; end
      if (reg_rd) begin reg_n++; saddr = reg_addr_o; end
      if (addr_read_en) pop_n++;
      if (data_fifo_wr_en) begin
        push_n++;
        if (push_k < 0) begin push_k = k; pdata = data_fifo_o; presp = resp_o; end
      end
      step();
    end
    check({tag, " mem_rd count"}, mem_n, v.exp_mem_n);
    check({tag, " reg_rd count"}, reg_n, v.exp_reg_n);
    check({tag, " strobe addr"}, saddr, (v.exp_mem_n + v.exp_reg_n > 0) ? v.addr : 32'h0);
    check({tag, " push cycle"}, push_k, v.exp_push_k);
    check({tag, " push count"}, push_n, 1);
    check({tag, " push data"}, pdata, v.exp_data);
    check({tag, " push resp"}, presp, v.exp_resp);
    check({tag, " extra pop"}, pop_n, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    int          pop_cyc[$];
    int          push_cyc[$];
    logic [31:0] push_dat[$];
    logic [1:0]  push_rsp[$];
    logic [31:0] exp_b2b_dat[3];
    logic [1:0]  exp_b2b_rsp[3];
    int          pending;
    int          late_push;

    vecs[0] = '{32'h0002_0104, 32'hDEAD_BEEF, 32'h0,         0, 1, 2, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h0002_0040, 32'h0,         32'h1234_5678, 1, 0, 3, 32'h1234_5678, 2'b00};
    vecs[2] = '{32'h0000_0100, 32'h0,         32'h0,         0, 0, 1, 32'h0,         2'b11};
    vecs[3] = '{32'h0002_0000, 32'h0,         32'hA5A5_5A5A, 1, 0, 3, 32'hA5A5_5A5A, 2'b00};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         0, 1, 2, 32'h0000_0001, 2'b00};
    vecs[5] = '{32'hFFFD_FFFF, 32'h0,         32'h0,         0, 0, 1, 32'h0,         2'b11};

    Rst            = 1'b1;
    addr_fifo_i    = 32'h0002_0104;
    addr_empty     = 1'b0;
    mem_data_i     = 32'h0;
    reg_data_i     = 32'h0;
    data_fifo_full = 1'b0;
    step();
    step();
    check("outputs in reset", any_out, 0);
    step();
    Rst = 1'b0;
    #1;
    check("outputs after reset", any_out, 0);
    check("no pop after reset", addr_read_en, 0);
    addr_empty = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: full for five PUSH cycles while the next address already waits.
    addr_fifo_i    = 32'h0002_0104;
    addr_empty     = 1'b0;
    data_fifo_full = 1'b1;
    reg_data_i     = 32'hCAFE_F00D;
    #1;
    check("bp pop", addr_read_en, 1);
    step();
    addr_fifo_i = 32'h0000_0000;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp wr_en held", data_fifo_wr_en, 0);
      check("bp data stable", data_fifo_o, 32'hCAFE_F00D);
      check("bp no pop", addr_read_en, 0);
      step();
    end
    data_fifo_full = 1'b0;
    #1;
    check("bp push on release", data_fifo_wr_en, 1);
    check("bp push data", data_fifo_o, 32'hCAFE_F00D);
    check("bp push resp", resp_o, 2'b00);
    step();
    #1;
    check("bp single push", data_fifo_wr_en, 0);
    check("bp next pop", addr_read_en, 1);
    step();
    addr_empty = 1'b1;
    step();
    #1;
    check("bp decerr push", data_fifo_wr_en, 1);
    check("bp decerr resp", resp_o, 2'b11);
    check("bp decerr data", data_fifo_o, 32'h0);
    step();

    // Back-to-back: reg, mem, unmapped queued in a FIFO model.
    q = '{32'h0002_0104, 32'h0002_0040, 32'h0000_0100};
    exp_b2b_dat = '{32'h1111_1111, 32'h2222_2222, 32'h0};
    exp_b2b_rsp = '{2'b00, 2'b00, 2'b11};
    reg_data_i = 32'h1111_1111;
    mem_data_i = 32'h2222_2222;
    pending = 0;
    for (int c = 0; c < 30; c++) begin
      if (pending != 0) begin
        void'(q.pop_front());
        pending = 0;
      end
      addr_empty  = (q.size() == 0);
      addr_fifo_i = (q.size() != 0) ? q[0] : 32'h0;
      #1;
      if (addr_read_en) begin
        pop_cyc.push_back(c);
        pending = 1;
      end
      if (data_fifo_wr_en) begin
        push_cyc.push_back(c);
        push_dat.push_back(data_fifo_o);
        push_rsp.push_back(resp_o);
      end
      step();
    end
    check("b2b pop count", pop_cyc.size(), 3);
    check("b2b push count", push_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("b2b spacing reg", pop_cyc[1] - pop_cyc[0], 4);
      check("b2b spacing mem", pop_cyc[2] - pop_cyc[1], 5);
      if (push_cyc.size() == 3) check("b2b decerr push cycle", push_cyc[2] - pop_cyc[2], 2);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < push_dat.size()) begin
        check($sformatf("b2b push%0d data", i), push_dat[i], exp_b2b_dat[i]);
        check($sformatf("b2b push%0d resp", i), push_rsp[i], exp_b2b_rsp[i]);
      end
    end

    // Reset during WAIT of a memory read.
    addr_fifo_i = 32'h0002_0040;
    addr_empty  = 1'b0;
    mem_data_i  = 32'h0;
    #1;
    check("rst pop", addr_read_en, 1);
    step();
    addr_empty = 1'b1;
    step();
    Rst = 1'b1;
    #1;
    check("rst outputs during", any_out, 0);
    step();
    Rst        = 1'b0;
    mem_data_i = 32'h1234_5678;
    #1;
    check("rst outputs after", any_out, 0);
    late_push = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      if (data_fifo_wr_en) late_push++;
    end
    check("rst no push", late_push, 0);
    check("rst data ignored", data_fifo_o, 32'h0);
    step();
    run_vec(vecs[1], "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
